// File: rtl/usb_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the USB core slave port.
// Define USB_WB_ARB_TIMEOUT_EN to build the ACCESS watchdog and error path.
module usb_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] m0_adr_i,
    input  logic [7:0] m0_dat_i,
    input  logic       m0_we_i,
    input  logic       m0_stb_i,
    output logic [7:0] m0_dat_o,
    output logic       m0_ack_o,
    output logic       m0_err_o,
    input  logic [7:0] m1_adr_i,
    input  logic [7:0] m1_dat_i,
    input  logic       m1_we_i,
    input  logic       m1_stb_i,
    output logic [7:0] m1_dat_o,
    output logic       m1_ack_o,
    output logic       m1_err_o,
    output logic [7:0] s_adr_o,
    output logic [7:0] s_dat_o,
    output logic       s_we_o,
    output logic       s_stb_o,
    input  logic [7:0] s_dat_i,
    input  logic       s_ack_i,
    output logic       grant_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t     state;
    logic       lastGnt;
    logic       pick;
    logic       ackSeen;
    logic       toExpire;
    logic [7:0] rspDat;

    // Contention goes to whoever was not served last.
    assign pick    = (m0_stb_i && m1_stb_i) ? ~lastGnt : m1_stb_i;
    assign ackSeen = s_stb_o && s_ack_i;
    assign rspDat  = s_we_o ? 8'h00 : s_dat_i;

`ifdef USB_WB_ARB_TIMEOUT_EN
    logic [TO_WIDTH-1:0] toCnt;
    logic                m0Err;
    logic                m1Err;

    assign toExpire = (state == ACCESS) &&
                      (toCnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
    assign m0_err_o = m0Err;
    assign m1_err_o = m1Err;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            toCnt <= '0;
            m0Err <= 1'b0;
            m1Err <= 1'b0;
        end else begin
            m0Err <= 1'b0;
            m1Err <= 1'b0;
            if (state != ACCESS) begin
                toCnt <= '0;
            end else begin
                toCnt <= toCnt + 1'b1;
                if (toExpire && !ackSeen) begin
                    m0Err <= ~grant_o;
                    m1Err <= grant_o;
                end
            end
        end
    end
`else
    logic unusedCfg;

    assign unusedCfg = ^{TIMEOUT_CYCLES[0], TO_WIDTH[0]};
    assign toExpire  = 1'b0;
    assign m0_err_o  = 1'b0;
    assign m1_err_o  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            lastGnt  <= 1'b1;
            grant_o  <= 1'b0;
            busy_o   <= 1'b0;
            s_adr_o  <= 8'h00;
            s_dat_o  <= 8'h00;
            s_we_o   <= 1'b0;
            s_stb_o  <= 1'b0;
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m0_dat_o <= 8'h00;
            m1_dat_o <= 8'h00;
        end else begin
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m0_dat_o <= 8'h00;
            m1_dat_o <= 8'h00;
            unique case (state)
                IDLE: begin
                    if (m0_stb_i || m1_stb_i) begin
                        state   <= ACCESS;
                        grant_o <= pick;
                        lastGnt <= pick;
                        busy_o  <= 1'b1;
                        s_stb_o <= 1'b1;
                        s_adr_o <= pick ? m1_adr_i : m0_adr_i;
                        s_dat_o <= pick ? m1_dat_i : m0_dat_i;
                        s_we_o  <= pick ? m1_we_i  : m0_we_i;
                    end
                end
                ACCESS: begin
                    if (ackSeen) begin
                        state   <= DONE;
                        s_stb_o <= 1'b0;
                        if (grant_o) begin
                            m1_ack_o <= 1'b1;
                            m1_dat_o <= rspDat;
                        end else begin
                            m0_ack_o <= 1'b1;
                            m0_dat_o <= rspDat;
                        end
                    end else if (toExpire) begin
                        state   <= DONE;
                        s_stb_o <= 1'b0;
                        if (grant_o) m1_dat_o <= 8'hFF;
                        else         m0_dat_o <= 8'hFF;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy_o  <= 1'b0;
                    s_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_wb_arbiter.sv
// Randomized bench for usb_wb_arbiter against a transaction-level model.
// Timeout checks are built when USB_WB_ARB_TIMEOUT_EN is defined.
module tb_usb_wb_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [7:0] m0Adr = '0, m0Dat = '0, m1Adr = '0, m1Dat = '0;
    logic       m0We = 1'b0, m0Stb = 1'b0, m1We = 1'b0, m1Stb = 1'b0;
    logic [7:0] m0DatO, m1DatO, sAdr, sDatO, sDatI;
    logic       m0Ack, m0Err, m1Ack, m1Err, sWe, sStb, sAck, grant, busy;

    int nChecks = 0;
    int nErrs = 0;
    int cyc = 0;
    int ptr = 1;
    int lat = 0;
    bit ackEn = 1'b1;
    bit lateAck = 1'b0;
    int n0Ack = 0, n1Ack = 0, n0Err = 0, n1Err = 0;
    int e0Ack = 0, e1Ack = 0, e0Err = 0, e1Err = 0;
    logic [7:0] refMem[256];

    // Slave core: acks after `lat` wait cycles, memory seeded by adr ^ B5.
    int         waitCnt = 0;
    logic [7:0] mem[256];
    bit [255:0] written;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        waitCnt <= sStb ? waitCnt + 1 : 0;
        if (sStb && sAck && sWe) begin
            mem[sAdr]     <= sDatO;
            written[sAdr] <= 1'b1;
        end
    end

    assign sAck  = (sStb && ackEn && waitCnt == lat) || lateAck;
    assign sDatI = written[sAdr] ? mem[sAdr] : (sAdr ^ 8'hB5);

    always @(negedge clk) begin
        if (m0Ack) n0Ack++;
        if (m1Ack) n1Ack++;
        if (m0Err) n0Err++;
        if (m1Err) n1Err++;
    end

    usb_wb_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .TO_WIDTH(3)
    ) dut (
        .clk_i(clk), .rst_ni(rstN),
        .m0_adr_i(m0Adr), .m0_dat_i(m0Dat), .m0_we_i(m0We), .m0_stb_i(m0Stb),
        .m0_dat_o(m0DatO), .m0_ack_o(m0Ack), .m0_err_o(m0Err),
        .m1_adr_i(m1Adr), .m1_dat_i(m1Dat), .m1_we_i(m1We), .m1_stb_i(m1Stb),
        .m1_dat_o(m1DatO), .m1_ack_o(m1Ack), .m1_err_o(m1Err),
        .s_adr_o(sAdr), .s_dat_o(sDatO), .s_we_o(sWe), .s_stb_o(sStb),
        .s_dat_i(sDatI), .s_ack_i(sAck),
        .grant_o(grant), .busy_o(busy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] allOuts();
        return {m0DatO, m0Ack, m0Err, m1DatO, m1Ack, m1Err,
                sAdr, sDatO, sWe, sStb, grant, busy};
    endfunction

    // One round: the selected masters strobe together and are served
    // in round-robin order; called and ending on a negedge.
    task automatic runRound(input bit r0, input bit r1,
                            input logic [7:0] a0, input logic [7:0] d0,
                            input bit w0,
                            input logic [7:0] a1, input logic [7:0] d1,
                            input bit w1, input int l);
        bit         pend[2];
        int         w, gEdge, expEdge, n;
        bit         got, scr;
        logic [7:0] ea, ed, expDat;
        bit         ew;
        lat   = l;
        ackEn = 1'b1;
        m0Adr = a0; m0Dat = d0; m0We = w0; m0Stb = r0;
        m1Adr = a1; m1Dat = d1; m1We = w1; m1Stb = r1;
        pend[0] = r0;
        pend[1] = r1;
        gEdge = cyc + 1;
        while (pend[0] || pend[1]) begin
            w = (pend[0] && pend[1]) ? 1 - ptr : (pend[1] ? 1 : 0);
            ptr = w;
            pend[w] = 1'b0;
            ea = w ? a1 : a0;
            ed = w ? d1 : d0;
            ew = w ? w1 : w0;
            expDat = ew ? 8'h00 : refMem[ea];
            expEdge = gEdge + 1 + l;
            scr = 1'($urandom_range(0, 1));
            n = 0;
            got = 1'b0;
            while (!got && n < 60) begin
                @(negedge clk);
                n++;
                if (scr && cyc == gEdge) begin
                    if (w == 1) begin
                        m1Adr = 8'($urandom); m1Dat = 8'($urandom);
                        m1We = 1'($urandom);
                    end else begin
                        m0Adr = 8'($urandom); m0Dat = 8'($urandom);
                        m0We = 1'($urandom);
                    end
                end
                got = (w == 1) ? (m1Ack || m1Err) : (m0Ack || m0Err);
            end
            check("ackSeen", got, 1);
            check("ackEdge", cyc, expEdge);
            if (w == 1) begin
                check("m1Rsp", {m1Ack, m1Err, m1DatO}, {2'b10, expDat});
                check("m0Idle", {m0Ack, m0Err, m0DatO}, 0);
            end else begin
                check("m0Rsp", {m0Ack, m0Err, m0DatO}, {2'b10, expDat});
                check("m1Idle", {m1Ack, m1Err, m1DatO}, 0);
            end
            check("sBus", {sAdr, sDatO, sWe, sStb}, {ea, ed, ew, 1'b0});
            check("gntBusy", {grant, busy}, {1'(w), 1'b1});
            if (ew) refMem[ea] = ed;
            if (w == 1) begin e1Ack++; m1Stb = 1'b0; end
            else        begin e0Ack++; m0Stb = 1'b0; end
            @(negedge clk);
            check("ackPulse", {m0Ack, m1Ack}, 0);
            gEdge = expEdge + 2;
        end
        @(negedge clk);
        @(negedge clk);
        check("idleBusy", {busy, sStb}, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) refMem[i] = 8'(i) ^ 8'hB5;
        repeat (3) @(negedge clk);
        check("rstOuts", allOuts(), 0);
        rstN = 1'b1;
        @(negedge clk);
        check("postRst", allOuts(), 0);

        runRound(1, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00, 0, 2);

        // Acks while nothing is on the bus must be dropped.
        lateAck = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("strayAck", {m0Ack, m1Ack, busy}, 0);
        end
        lateAck = 1'b0;

        runRound(1, 1, 8'h21, 8'h00, 0, 8'h22, 8'h00, 0, 0);
        runRound(1, 1, 8'h31, 8'h77, 1, 8'h32, 8'h00, 0, 1);
        runRound(0, 1, 8'h00, 8'h00, 0, 8'h02, 8'h3C, 1, 1);
        runRound(1, 0, 8'h02, 8'h00, 0, 8'h00, 8'h00, 0, 3);

`ifdef USB_WB_ARB_TIMEOUT_EN
        begin
            int gEdge, n;
            ackEn = 1'b0;
            m0Adr = 8'h20; m0We = 1'b0; m0Stb = 1'b1;
            gEdge = cyc + 1;
            n = 0;
            while (!m0Err && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("errEdge", cyc, gEdge + TO);
            check("errRsp", {m0Err, m0Ack, m0DatO}, {2'b10, 8'hFF});
            check("errOther", {m1Err, m1Ack, m1DatO}, 0);
            ptr = 0;
            e0Err++;
            m0Stb = 1'b0;
            @(negedge clk);
            check("errPulse", m0Err, 0);
            lateAck = 1'b1;
            repeat (3) begin
                @(negedge clk);
                check("lateAck", {m0Ack, m1Ack, busy}, 0);
            end
            lateAck = 1'b0;
            ackEn = 1'b1;
        end
`endif

        // Reset in the middle of an access abandons it.
        ackEn = 1'b0;
        m1Adr = 8'h44; m1Dat = 8'h99; m1We = 1'b1; m1Stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midAcc", {sStb, busy, grant}, 3'b111);
        rstN = 1'b0;
        @(negedge clk);
        check("midRst", allOuts(), 0);
        m1Stb = 1'b0;
        rstN = 1'b1;
        ackEn = 1'b1;
        ptr = 1;
        @(negedge clk);
        check("rstIdle", allOuts(), 0);
        runRound(1, 1, 8'h44, 8'h00, 0, 8'h45, 8'h00, 0, 0);

        for (int k = 0; k < 40; k++) begin
            bit r0, r1;
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            runRound(r0, r1,
                     8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom),
                     8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom),
                     $urandom_range(0, 3));
        end

        check("m0AckCnt", n0Ack, e0Ack);
        check("m1AckCnt", n1Ack, e1Ack);
        check("m0ErrCnt", n0Err, e0Err);
        check("m1ErrCnt", n1Err, e1Err);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrs);
        $finish;
    end

endmodule
